// File: rtl/piano_if.sv
// Key/buzzer bundle for the piano tone generator: raw active-low buttons in, square wave out.
interface piano_if;
  logic [3:0] keys;
  logic       out;

  modport master (output keys, input out);
  modport slave  (input keys, output out);
endinterface

// File: rtl/piano.sv
// Four-key tone generator: synchronise and debounce the buttons, pick the highest-priority
// held key and drive a 50 % square wave at its pitch. Macro PIANO_DEBOUNCE_EN builds the debounce filter.
module piano #(
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned HALF0        = 95_420,
  parameter int unsigned HALF1        = 85_034,
  parameter int unsigned HALF2        = 75_758,
  parameter int unsigned HALF3        = 71_633
) (
  input  logic   clk,
  input  logic   rst_n,
  piano_if.slave bus
);

  localparam int unsigned NKEYS = 4;
  localparam int unsigned HC_W  = 17;

  // Reject parameter sets the counters cannot represent.
  if (CLK_FREQ == 0 || DEBOUNCE_CYC == 0 ||
      HALF0 == 0 || HALF1 == 0 || HALF2 == 0 || HALF3 == 0 ||
      HALF0 >= (1 << HC_W) || HALF1 >= (1 << HC_W) ||
      HALF2 >= (1 << HC_W) || HALF3 >= (1 << HC_W)) begin : g_cfg_check
    $error("piano: invalid parameter set");
  end

  logic [NKEYS-1:0] sync1, sync2, kd;
  logic [1:0]       sel, sel_nxt;
  logic             valid, valid_nxt;
  logic [HC_W-1:0]  half, half_nxt, hc;
  logic             tone;

  // rst_n is an active-high synchronous reset despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.keys;
      sync2 <= sync1;
    end
  end

`ifdef PIANO_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [CNT_W-1:0] cnt [NKEYS];

  // Per-key filter: kd follows sync2 only after DEBOUNCE_CYC cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      kd <= '1;
      for (int unsigned i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (sync2[i] == kd[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          kd[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign kd = sync2;
`endif

  // Lowest-numbered pressed key wins.
  always_comb begin
    sel_nxt   = 2'd0;
    valid_nxt = ~&kd;
    half_nxt  = HC_W'(HALF0);
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (!kd[i]) sel_nxt = 2'(i);
    end
    case (sel_nxt)
      2'd0:    half_nxt = HC_W'(HALF0);
      2'd1:    half_nxt = HC_W'(HALF1);
      2'd2:    half_nxt = HC_W'(HALF2);
      default: half_nxt = HC_W'(HALF3);
    endcase
  end

  // Any change of selection restarts the tone from a low phase.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sel   <= 2'd0;
      valid <= 1'b0;
      half  <= HC_W'(HALF0);
      hc    <= '0;
      tone  <= 1'b0;
    end else begin
      sel   <= sel_nxt;
      valid <= valid_nxt;
      half  <= half_nxt;
      if (sel_nxt != sel || valid_nxt != valid || !valid) begin
        hc   <= '0;
        tone <= 1'b0;
      end else if (hc == half - HC_W'(1)) begin
        hc   <= '0;
        tone <= ~tone;
      end else begin
        hc <= hc + HC_W'(1);
      end
    end
  end

  assign bus.out = tone;

endmodule

// File: tb/tb_piano.sv
// Directed bench for piano with shortened debounce and half-periods; follows PIANO_DEBOUNCE_EN.
module tb_piano;

  localparam int unsigned DEB_CYC = 40;
  localparam int unsigned H0 = 12;
  localparam int unsigned H1 = 10;
  localparam int unsigned H2 = 8;
  localparam int unsigned H3 = 6;
`ifdef PIANO_DEBOUNCE_EN
  localparam int unsigned DEB = DEB_CYC;
  localparam int unsigned GL  = DEB_CYC - 1;
`else
  localparam int unsigned DEB = 0;
  localparam int unsigned GL  = 5;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  piano_if pif ();

  piano #(
    .CLK_FREQ    (50_000_000),
    .DEBOUNCE_CYC(DEB_CYC),
    .HALF0       (H0),
    .HALF1       (H1),
    .HALF2       (H2),
    .HALF3       (H3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic bad;
    pif.keys = 4'hF;
    rst_n    = 1'b1;
    tick(3);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b want 0", pif.out); end
    checks++;
    if (dut.kd !== 4'hF) begin errors++; $display("FAIL reset_kd: got %b want 1111", dut.kd); end
    pif.keys = 4'h0;
    tick(5);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL reset_keys_low_out: got %b want 0", pif.out); end
    checks++;
    if (dut.kd !== 4'hF) begin errors++; $display("FAIL reset_keys_low_kd: got %b want 1111", dut.kd); end
    pif.keys = 4'hF;
    rst_n    = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < int'(DEB + 3 * H0); c++) begin
      tick(1);
      if (pif.out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL idle_quiet: out went %b while idle, want 0", bad); end
  endtask

  task automatic test_bounce_press;
    logic bad;
    bad = 1'b0;
    pif.keys = 4'hF;
    for (int t = 0; t < 5; t++) begin
      pif.keys[0] = ~pif.keys[0];
      if (t < 4) begin
        for (int c = 0; c < 10; c++) begin
          tick(1);
          if (pif.out !== 1'b0) bad = 1'b1;
        end
      end
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL bounce_quiet: out seen %b during bounce, want 0", bad); end
    tick(3 + DEB + H0 - 1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL press_before_rise: got %b want 0", pif.out); end
    checks++;
    if (dut.kd !== 4'hE) begin errors++; $display("FAIL press_kd: got %b want 1110", dut.kd); end
    tick(1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL press_rise: got %b want 1", pif.out); end
    tick(H0 - 1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL press_high_hold: got %b want 1", pif.out); end
    tick(1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL press_fall: got %b want 0", pif.out); end
    tick(H0);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL press_period: got %b want 1", pif.out); end
  endtask

  task automatic test_priority;
    pif.keys = 4'b0101;
    tick(3 + DEB);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL prio_restart_h1: got %b want 0", pif.out); end
    tick(H1 - 1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL prio_h1_low: got %b want 0", pif.out); end
    tick(1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL prio_h1_rise: got %b want 1", pif.out); end
    tick(H1 - 1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL prio_h1_hold: got %b want 1", pif.out); end
    tick(1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL prio_h1_fall: got %b want 0", pif.out); end
    pif.keys = 4'b0111;
    tick(3 + DEB);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL prio_restart_h3: got %b want 0", pif.out); end
    tick(H3 - 1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL prio_h3_low: got %b want 0", pif.out); end
    tick(1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL prio_h3_rise: got %b want 1", pif.out); end
    tick(H3 - 1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL prio_h3_hold: got %b want 1", pif.out); end
    tick(1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL prio_h3_fall: got %b want 0", pif.out); end
  endtask

  task automatic test_release;
    logic bad;
    pif.keys = 4'hF;
    tick(10);
    pif.keys = 4'h7;
    tick(10);
    pif.keys = 4'hF;
    tick(DEB + 4);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL release_out: got %b want 0", pif.out); end
    checks++;
    if (dut.kd !== 4'hF) begin errors++; $display("FAIL release_kd: got %b want 1111", dut.kd); end
    bad = 1'b0;
    for (int c = 0; c < int'(4 * H0); c++) begin
      tick(1);
      if (pif.out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL release_stays_low: out seen %b, want 0", bad); end
  endtask

  task automatic test_glitch;
    logic bad_out;
    logic bad_kd;
    bad_out  = 1'b0;
    bad_kd   = 1'b0;
    pif.keys = 4'b1011;
    for (int c = 0; c < int'(GL + DEB + 20); c++) begin
      if (c == int'(GL)) pif.keys = 4'hF;
      tick(1);
      if (pif.out !== 1'b0) bad_out = 1'b1;
      if (dut.kd[2] !== 1'b1) bad_kd = 1'b1;
    end
    checks++;
    if (bad_out !== 1'b0) begin errors++; $display("FAIL glitch_out: out seen %b, want 0", bad_out); end
`ifdef PIANO_DEBOUNCE_EN
    checks++;
    if (bad_kd !== 1'b0) begin errors++; $display("FAIL glitch_kd: kd[2] dropped (%b), want stable 1", bad_kd); end
`endif
  endtask

  task automatic test_reset_mid;
    logic bad;
    pif.keys = 4'b0111;
    tick(3 + DEB + H3);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL mid_tone_up: got %b want 1", pif.out); end
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (pif.out !== 1'b0) begin errors++; $display("FAIL mid_reset_out: got %b want 0", pif.out); end
    checks++;
    if (dut.kd !== 4'hF) begin errors++; $display("FAIL mid_reset_kd: got %b want 1111", dut.kd); end
    tick(2);
    rst_n = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < int'(3 + DEB + H3 - 1); c++) begin
      tick(1);
      if (pif.out !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL mid_no_early_tone: out seen %b, want 0", bad); end
    tick(1);
    checks++;
    if (pif.out !== 1'b1) begin errors++; $display("FAIL mid_resume: got %b want 1", pif.out); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    pif.keys = 4'hF;
    test_reset();
    test_bounce_press();
    test_priority();
    test_release();
    test_glitch();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
